// File: rtl/pip_ctrl_multi_pkg.sv
// Shared definitions for the pipeline controller: FSM encodings, stage indices, watchdog width.
package pip_ctrl_multi_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_FREEZE = 2'd1,
    ST_FLUSH  = 2'd2
  } pip_state_e;

  typedef enum logic [3:0] {
    STG_PC  = 4'd0,
    STG_IF  = 4'd1,
    STG_ID  = 4'd2,
    STG_EX  = 4'd3,
    STG_MEM = 4'd4,
    STG_WB  = 4'd5
  } pip_stage_e;

  localparam int WDOG_W = 10;

endpackage

// File: rtl/pip_ctrl_multi_stall_wdog.sv
// Stall watchdog: saturating count of consecutive stalled cycles, sticky timeout flag.
// Latency: timeout rises on the same edge the count reaches LIMIT; never stalls anything itself.
module stall_wdog
  import pip_ctrl_multi_pkg::*;
#(
  parameter int LIMIT = 1023
) (
  input  logic clk,
  input  logic resetn,
  input  logic stall_i,
  output logic timeout_o
);

  localparam logic [WDOG_W-1:0] LIMIT_V = WDOG_W'(LIMIT);

  logic [WDOG_W-1:0] cnt_q, cnt_d;
  logic              timeout_q, timeout_d;

  always_comb begin
    cnt_d = '0;
    if (stall_i) cnt_d = (&cnt_q) ? cnt_q : cnt_q + WDOG_W'(1);
    timeout_d = timeout_q | (cnt_d >= LIMIT_V);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_o = timeout_q;

endmodule

// File: rtl/pip_ctrl_multi.sv
// Pipeline controller: per-stage stall requests, global freeze, exception flush (optional perf counters: PIP_CTRL_PERF_EN).
// Stall/bubble/flush are combinational in the request cycle; freeze beats exception beats stall requests.
module pip_ctrl_multi
  import pip_ctrl_multi_pkg::*;
#(
  parameter int                   NUM_STAGES    = 6,
  parameter int                   NUM_REQ       = 2,
  parameter logic [4*NUM_REQ-1:0] REQ_STAGE_MAP = {4'd3, 4'd2},
  parameter int                   FLUSH_CYCLES  = 1,
  parameter int                   WDOG_LIMIT    = 1023
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [NUM_REQ-1:0]    stallreq,
  input  logic                  freeze_req,
  input  logic                  except_en,
  output logic [NUM_STAGES-1:0] stall,
  output logic [NUM_STAGES-1:0] bubble,
  output logic                  flush,
  output logic                  busy_flush,
  output logic                  stall_timeout
`ifdef PIP_CTRL_PERF_EN
  ,
  output logic [31:0]           perf_stall_cnt,
  output logic [31:0]           perf_flush_cnt
`endif
);

  localparam int              CNT_W     = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] FC_RELOAD = CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [3:0]       LAST_STG  = 4'(NUM_STAGES - 1);

  pip_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              pend_q, pend_d;

  logic [3:0]            s_max, ent;
  logic                  any_req;
  logic [NUM_STAGES-1:0] run_stall, run_bubble, stall_c, bubble_c;
  logic                  flush_c, busy_c;

  // Deepest requesting stage, with out-of-range map entries clamped to writeback.
  always_comb begin
    s_max   = '0;
    ent     = '0;
    any_req = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (stallreq[i]) begin
        ent = REQ_STAGE_MAP[4*i +: 4];
        if (ent > LAST_STG) ent = LAST_STG;
        if (ent >= s_max) s_max = ent;
        any_req = 1'b1;
      end
    end
    for (int k = 0; k < NUM_STAGES; k++) begin
      run_stall[k]  = any_req && (4'(k) <= s_max);
      run_bubble[k] = any_req && (5'(k) == ({1'b0, s_max} + 5'd1));
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pend_d   = pend_q;
    stall_c  = '0;
    bubble_c = '0;
    flush_c  = 1'b0;
    busy_c   = 1'b0;
    unique case (state_q)
      ST_FLUSH: begin
        flush_c = 1'b1;
        busy_c  = 1'b1;
        if (except_en) cnt_d = FC_RELOAD;
        if (freeze_req) begin
          stall_c = '1;
        end else if (!except_en) begin
          if (cnt_q <= CNT_W'(1)) state_d = ST_RUN;
          else                    cnt_d   = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        // An exception seen under freeze is parked and replayed when the freeze lifts.
        if (freeze_req) begin
          stall_c = '1;
          state_d = ST_FREEZE;
          if (except_en) pend_d = 1'b1;
        end else if (except_en || pend_q) begin
          flush_c = 1'b1;
          pend_d  = 1'b0;
          cnt_d   = FC_RELOAD;
          state_d = (FLUSH_CYCLES > 1) ? ST_FLUSH : ST_RUN;
        end else begin
          stall_c  = run_stall;
          bubble_c = run_bubble;
          state_d  = ST_RUN;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
    end
  end

  // Combinational outputs are forced quiet while reset is held.
  assign stall      = resetn ? stall_c  : '0;
  assign bubble     = resetn ? bubble_c : '0;
  assign flush      = resetn & flush_c;
  assign busy_flush = resetn & busy_c;

  stall_wdog #(
    .LIMIT(WDOG_LIMIT)
  ) u_wdog (
    .clk      (clk),
    .resetn   (resetn),
    .stall_i  (stall[STG_PC]),
    .timeout_o(stall_timeout)
  );

`ifdef PIP_CTRL_PERF_EN
  logic [31:0] perf_stall_q, perf_flush_q;
  logic        flush_evt;

  // One event per accepted exception, including a restart inside an ongoing flush.
  assign flush_evt = flush && ((state_q != ST_FLUSH) || except_en);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      if (stall[STG_PC]) perf_stall_q <= perf_stall_q + 32'd1;
      if (flush_evt)     perf_flush_q <= perf_flush_q + 32'd1;
    end
  end

  assign perf_stall_cnt = perf_stall_q;
  assign perf_flush_cnt = perf_flush_q;
`endif

endmodule

// File: tb/tb_pip_ctrl_multi.sv
// Directed bench for pip_ctrl_multi (FLUSH_CYCLES=2, map {3,2}); a second instance with WDOG_LIMIT=8 covers the watchdog.
module tb_pip_ctrl_multi;
  logic       clk = 1'b0;
  logic       resetn;
  logic [1:0] stallreq;
  logic       freeze_req, except_en;

  logic [5:0] stall, bubble, stall_w, bubble_w;
  logic       flush, busy_flush, stall_timeout;
  logic       flush_w, busy_flush_w, stall_timeout_w;
`ifdef PIP_CTRL_PERF_EN
  logic [31:0] perf_stall_cnt, perf_flush_cnt, perf_stall_cnt_w, perf_flush_cnt_w;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pip_ctrl_multi #(
    .NUM_STAGES(6), .NUM_REQ(2), .REQ_STAGE_MAP({4'd3, 4'd2}), .FLUSH_CYCLES(2), .WDOG_LIMIT(1023)
  ) dut (
    .clk(clk), .resetn(resetn), .stallreq(stallreq), .freeze_req(freeze_req), .except_en(except_en),
    .stall(stall), .bubble(bubble), .flush(flush), .busy_flush(busy_flush), .stall_timeout(stall_timeout)
`ifdef PIP_CTRL_PERF_EN
    , .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
  );

  pip_ctrl_multi #(
    .NUM_STAGES(6), .NUM_REQ(2), .REQ_STAGE_MAP({4'd3, 4'd2}), .FLUSH_CYCLES(2), .WDOG_LIMIT(8)
  ) dut_w (
    .clk(clk), .resetn(resetn), .stallreq(stallreq), .freeze_req(freeze_req), .except_en(except_en),
    .stall(stall_w), .bubble(bubble_w), .flush(flush_w), .busy_flush(busy_flush_w), .stall_timeout(stall_timeout_w)
`ifdef PIP_CTRL_PERF_EN
    , .perf_stall_cnt(perf_stall_cnt_w), .perf_flush_cnt(perf_flush_cnt_w)
`endif
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0; stallreq = 2'b11; freeze_req = 1'b1; except_en = 1'b1;
    cyc();
    @(negedge clk);
    checks++; if (stall !== 6'b0) begin failures++; $display("FAIL reset_stall got=%b exp=%b", stall, 6'b0); end
    checks++; if (bubble !== 6'b0) begin failures++; $display("FAIL reset_bubble got=%b exp=%b", bubble, 6'b0); end
    checks++; if (flush !== 1'b0) begin failures++; $display("FAIL reset_flush got=%b exp=0", flush); end
    checks++; if (busy_flush !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy_flush); end
    checks++; if (stall_timeout !== 1'b0) begin failures++; $display("FAIL reset_timeout got=%b exp=0", stall_timeout); end
    cyc();
    stallreq = 2'b00; freeze_req = 1'b0; except_en = 1'b0; resetn = 1'b1;
    @(negedge clk);
    checks++; if (stall !== 6'b0 || flush !== 1'b0) begin failures++; $display("FAIL post_reset_idle got stall=%b flush=%b exp 000000/0", stall, flush); end
    cyc();
    stallreq = 2'b01;
    @(negedge clk);
    checks++; if (stall !== 6'b000111) begin failures++; $display("FAIL post_reset_run got=%b exp=000111", stall); end
    cyc();
    stallreq = 2'b00;
    cyc();
  endtask

  task automatic test_stall();
    logic [1:0] req_v [4]    = '{2'b01, 2'b11, 2'b10, 2'b00};
    logic [5:0] stall_v [4]  = '{6'b000111, 6'b001111, 6'b001111, 6'b000000};
    logic [5:0] bubble_v [4] = '{6'b001000, 6'b010000, 6'b010000, 6'b000000};
    for (int i = 0; i < 4; i++) begin
      stallreq = req_v[i];
      @(negedge clk);
      checks++; if (stall !== stall_v[i]) begin failures++; $display("FAIL stall_vec req=%b got=%b exp=%b", req_v[i], stall, stall_v[i]); end
      checks++; if (bubble !== bubble_v[i]) begin failures++; $display("FAIL bubble_vec req=%b got=%b exp=%b", req_v[i], bubble, bubble_v[i]); end
      cyc();
    end
  endtask

  task automatic test_except();
    except_en = 1'b1;
    @(negedge clk);
    checks++; if ({flush, busy_flush, stall} !== {1'b1, 1'b0, 6'b0}) begin failures++; $display("FAIL except_c0 got flush=%b busy=%b stall=%b exp 1/0/000000", flush, busy_flush, stall); end
    cyc();
    except_en = 1'b0;
    @(negedge clk);
    checks++; if ({flush, busy_flush, stall} !== {1'b1, 1'b1, 6'b0}) begin failures++; $display("FAIL except_c1 got flush=%b busy=%b stall=%b exp 1/1/000000", flush, busy_flush, stall); end
    cyc();
    @(negedge clk);
    checks++; if ({flush, busy_flush} !== 2'b00) begin failures++; $display("FAIL except_c2 got flush=%b busy=%b exp 0/0", flush, busy_flush); end
    cyc();
  endtask

  task automatic test_priority();
    stallreq = 2'b11; except_en = 1'b1;
    @(negedge clk);
    checks++; if ({flush, stall, bubble} !== {1'b1, 12'b0}) begin failures++; $display("FAIL exc_over_stall got flush=%b stall=%b bubble=%b exp 1/0/0", flush, stall, bubble); end
    cyc();
    except_en = 1'b0;
    @(negedge clk);
    checks++; if ({busy_flush, stall, bubble} !== {1'b1, 12'b0}) begin failures++; $display("FAIL flush_ignores_req got busy=%b stall=%b bubble=%b exp 1/0/0", busy_flush, stall, bubble); end
    cyc();
    @(negedge clk);
    checks++; if (stall !== 6'b001111) begin failures++; $display("FAIL req_after_flush got=%b exp=001111", stall); end
    cyc();
    stallreq = 2'b01; freeze_req = 1'b1;
    @(negedge clk);
    checks++; if ({stall, bubble} !== {6'b111111, 6'b0}) begin failures++; $display("FAIL freeze_over_req got stall=%b bubble=%b exp 111111/000000", stall, bubble); end
    cyc();
    freeze_req = 1'b0;
    @(negedge clk);
    checks++; if ({stall, flush} !== {6'b000111, 1'b0}) begin failures++; $display("FAIL unfreeze_no_exc got stall=%b flush=%b exp 000111/0", stall, flush); end
    cyc();
    stallreq = 2'b00;
    cyc();
  endtask

  task automatic test_freeze();
    freeze_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      except_en = (i == 1);
      @(negedge clk);
      checks++; if ({stall, flush} !== {6'b111111, 1'b0}) begin failures++; $display("FAIL freeze_c%0d got stall=%b flush=%b exp 111111/0", i, stall, flush); end
      cyc();
    end
    freeze_req = 1'b0; except_en = 1'b0;
    @(negedge clk);
    checks++; if ({flush, stall} !== {1'b1, 6'b0}) begin failures++; $display("FAIL freeze_drop got flush=%b stall=%b exp 1/000000", flush, stall); end
    cyc();
    cyc();
    @(negedge clk);
    checks++; if (flush !== 1'b0) begin failures++; $display("FAIL freeze_settle got flush=%b exp=0", flush); end
    cyc();
  endtask

  task automatic test_flush_restart();
    except_en = 1'b1;
    cyc();
    @(negedge clk);
    checks++; if ({flush, busy_flush} !== 2'b11) begin failures++; $display("FAIL restart_c1 got flush=%b busy=%b exp 1/1", flush, busy_flush); end
    cyc();
    except_en = 1'b0;
    @(negedge clk);
    checks++; if ({flush, busy_flush} !== 2'b11) begin failures++; $display("FAIL restart_c2 got flush=%b busy=%b exp 1/1", flush, busy_flush); end
    cyc();
    @(negedge clk);
    checks++; if (flush !== 1'b0) begin failures++; $display("FAIL restart_c3 got flush=%b exp=0", flush); end
    // Freeze inside FLUSH holds flush and the count.
    except_en = 1'b1;
    cyc();
    except_en = 1'b0; freeze_req = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++; if ({stall, flush, busy_flush} !== {6'b111111, 2'b11}) begin failures++; $display("FAIL flush_freeze_c%0d got stall=%b flush=%b busy=%b exp 111111/1/1", i, stall, flush, busy_flush); end
      cyc();
    end
    freeze_req = 1'b0;
    @(negedge clk);
    checks++; if ({stall, flush, busy_flush} !== {6'b0, 2'b11}) begin failures++; $display("FAIL flush_unfreeze got stall=%b flush=%b busy=%b exp 000000/1/1", stall, flush, busy_flush); end
    cyc();
    @(negedge clk);
    checks++; if (flush !== 1'b0) begin failures++; $display("FAIL flush_freeze_end got flush=%b exp=0", flush); end
    cyc();
  endtask

  task automatic test_wdog();
    stallreq = 2'b00;
    cyc();
    stallreq = 2'b01;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++; if (stall_timeout_w !== 1'b0) begin failures++; $display("FAIL wdog_early_c%0d got=%b exp=0", i, stall_timeout_w); end
      cyc();
    end
    @(negedge clk);
    checks++; if (stall_timeout_w !== 1'b1) begin failures++; $display("FAIL wdog_expire got=%b exp=1", stall_timeout_w); end
    checks++; if (stall_timeout !== 1'b0) begin failures++; $display("FAIL wdog_big_limit got=%b exp=0", stall_timeout); end
    cyc();
    stallreq = 2'b00;
    cyc();
    cyc();
    @(negedge clk);
    checks++; if (stall_timeout_w !== 1'b1) begin failures++; $display("FAIL wdog_sticky got=%b exp=1", stall_timeout_w); end
    resetn = 1'b0;
    #2;
    checks++; if (stall_timeout_w !== 1'b0) begin failures++; $display("FAIL wdog_reset got=%b exp=0", stall_timeout_w); end
    cyc();
    resetn = 1'b1;
    cyc();
  endtask

  task automatic test_reset_mid_flush();
    except_en = 1'b1;
    cyc();
    except_en = 1'b0;
    @(negedge clk);
    checks++; if (busy_flush !== 1'b1) begin failures++; $display("FAIL midflush_pre got busy=%b exp=1", busy_flush); end
    resetn = 1'b0;
    #2;
    checks++; if ({flush, busy_flush} !== 2'b00) begin failures++; $display("FAIL midflush_rst got flush=%b busy=%b exp 0/0", flush, busy_flush); end
    cyc();
    resetn = 1'b1;
    @(negedge clk);
    checks++; if ({flush, busy_flush} !== 2'b00) begin failures++; $display("FAIL midflush_after got flush=%b busy=%b exp 0/0", flush, busy_flush); end
    cyc();
  endtask

`ifdef PIP_CTRL_PERF_EN
  task automatic test_perf();
    resetn = 1'b0;
    cyc();
    resetn = 1'b1;
    cyc();
    for (int i = 0; i < 3; i++) begin
      except_en = 1'b1;
      cyc();
      except_en = 1'b0;
      cyc();
      cyc();
    end
    stallreq = 2'b01;
    repeat (10) cyc();
    stallreq = 2'b00;
    @(negedge clk);
    checks++; if (perf_flush_cnt !== 32'd3) begin failures++; $display("FAIL perf_flush got=%0d exp=3", perf_flush_cnt); end
    checks++; if (perf_stall_cnt !== 32'd10) begin failures++; $display("FAIL perf_stall got=%0d exp=10", perf_stall_cnt); end
    cyc();
  endtask
`endif

  initial begin
    resetn = 1'b0; stallreq = 2'b00; freeze_req = 1'b0; except_en = 1'b0;
    test_reset();
    test_stall();
    test_except();
    test_priority();
    test_freeze();
    test_flush_restart();
    test_wdog();
    test_reset_mid_flush();
`ifdef PIP_CTRL_PERF_EN
    test_perf();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
